// File: rtl/uart_alu_ctrl_pkg.sv
// Shared definitions for the UART ALU datapath: widths, opcodes, sequencer states.
// The ALU evaluation function lives here so the ALU and the controller agree on the opcode set.
package uart_alu_defs;

    localparam int NB_DATA_DEF    = 8;
    localparam int NB_OP_DEF      = 6;
    localparam int NB_TIMEOUT_DEF = 24;
    localparam int N_TIMEOUT_DEF  = 1000000;
    localparam int NB_STATE       = 3;

    localparam logic [NB_OP_DEF-1:0] OP_ADD = 6'b100000;
    localparam logic [NB_OP_DEF-1:0] OP_SUB = 6'b100010;
    localparam logic [NB_OP_DEF-1:0] OP_AND = 6'b100100;
    localparam logic [NB_OP_DEF-1:0] OP_OR  = 6'b100101;
    localparam logic [NB_OP_DEF-1:0] OP_XOR = 6'b100110;
    localparam logic [NB_OP_DEF-1:0] OP_NOR = 6'b100111;
    localparam logic [NB_OP_DEF-1:0] OP_SRA = 6'b000011;
    localparam logic [NB_OP_DEF-1:0] OP_SRL = 6'b000010;

    typedef enum logic [NB_STATE-1:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT_B  = 3'd1,
        ST_WAIT_OP = 3'd2,
        ST_EXEC    = 3'd3,
        ST_SEND    = 3'd4,
        ST_WAIT_TX = 3'd5
    } state_t;

    function automatic logic op_is_valid(input logic [NB_OP_DEF-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_NOR, OP_SRA, OP_SRL: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

    // Shift amounts use the operand B value directly; out-of-range shifts saturate naturally.
    function automatic logic [NB_DATA_DEF-1:0] alu_eval(
        input logic [NB_DATA_DEF-1:0] a,
        input logic [NB_DATA_DEF-1:0] b,
        input logic [NB_OP_DEF-1:0]   op
    );
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_NOR:  return ~(a | b);
            OP_SRA:  return NB_DATA_DEF'($signed(a) >>> b);
            OP_SRL:  return a >> b;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/uart_alu_ctrl_timer.sv
// Inter-byte timeout counter: clears on demand, counts while enabled.
// expired is combinational and flags the last cycle before the count would reach N_TIMEOUT-1.
module inter_byte_timer #(
    parameter int NB_TIMEOUT = 24,
    parameter int N_TIMEOUT  = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [NB_TIMEOUT-1:0] LAST = NB_TIMEOUT'(N_TIMEOUT - 2);

    logic [NB_TIMEOUT-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + NB_TIMEOUT'(1);
        end
    end

    // Raised one cycle early so the registered timeout pulse lands as the count reaches N_TIMEOUT-1.
    assign expired = enable && (count == LAST);

endmodule

// File: rtl/uart_alu_ctrl.sv
// Sequences RX bytes A, B, opcode into the ALU and launches one TX of the result; tx_start 2 cycles after the opcode tick.
// No backpressure: bytes arriving while executing or transmitting are dropped and flagged as overrun.
module uart_alu_ctrl
    import uart_alu_defs::*;
#(
    parameter int NB_DATA    = NB_DATA_DEF,
    parameter int NB_OP      = NB_OP_DEF,
    parameter int NB_TIMEOUT = NB_TIMEOUT_DEF,
    parameter int N_TIMEOUT  = N_TIMEOUT_DEF
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_rx_done_tick,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_tx_done_tick,
    input  logic [NB_DATA-1:0] i_alu_result,
    output logic [NB_DATA-1:0] o_alu_a,
    output logic [NB_DATA-1:0] o_alu_b,
    output logic [NB_OP-1:0]   o_alu_op,
    output logic               o_tx_start,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_busy,
    output logic               o_timeout,
    output logic               o_op_err,
    output logic               o_overrun
);

    state_t state, state_nxt;

    logic [NB_DATA-1:0] alu_a_nxt, alu_b_nxt, tx_data_nxt;
    logic [NB_OP-1:0]   alu_op_nxt;
    logic               tx_start_nxt, timeout_nxt, op_err_nxt, overrun_nxt;
    logic               timer_clear, timer_en, timer_expired;
    logic               op_byte_ok;

    assign op_byte_ok = ((i_rx_data >> NB_OP) == '0) && op_is_valid(i_rx_data[NB_OP-1:0]);

    inter_byte_timer #(
        .NB_TIMEOUT (NB_TIMEOUT),
        .N_TIMEOUT  (N_TIMEOUT)
    ) u_timer (
        .clk     (i_clock),
        .rst_n   (i_reset),
        .clear   (timer_clear),
        .enable  (timer_en),
        .expired (timer_expired)
    );

    always_comb begin
        state_nxt    = state;
        alu_a_nxt    = o_alu_a;
        alu_b_nxt    = o_alu_b;
        alu_op_nxt   = o_alu_op;
        tx_data_nxt  = o_tx_data;
        tx_start_nxt = 1'b0;
        timeout_nxt  = 1'b0;
        op_err_nxt   = 1'b0;
        overrun_nxt  = 1'b0;
        timer_clear  = 1'b1;
        timer_en     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (i_rx_done_tick) begin
                    alu_a_nxt = i_rx_data;
                    state_nxt = ST_WAIT_B;
                end
            end
            ST_WAIT_B: begin
                timer_en    = 1'b1;
                timer_clear = i_rx_done_tick || timer_expired;
                if (i_rx_done_tick) begin
                    alu_b_nxt = i_rx_data;
                    state_nxt = ST_WAIT_OP;
                end else if (timer_expired) begin
                    timeout_nxt = 1'b1;
                    state_nxt   = ST_IDLE;
                end
            end
            ST_WAIT_OP: begin
                timer_en    = 1'b1;
                timer_clear = i_rx_done_tick || timer_expired;
                if (i_rx_done_tick) begin
                    if (op_byte_ok) begin
                        alu_op_nxt = i_rx_data[NB_OP-1:0];
                        state_nxt  = ST_EXEC;
                    end else begin
                        op_err_nxt = 1'b1;
                        state_nxt  = ST_IDLE;
                    end
                end else if (timer_expired) begin
                    timeout_nxt = 1'b1;
                    state_nxt   = ST_IDLE;
                end
            end
            ST_EXEC: begin
                // Registered operands have settled through the ALU by now.
                tx_data_nxt  = i_alu_result;
                tx_start_nxt = 1'b1;
                overrun_nxt  = i_rx_done_tick;
                state_nxt    = ST_SEND;
            end
            ST_SEND: begin
                overrun_nxt = i_rx_done_tick;
                state_nxt   = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                overrun_nxt = i_rx_done_tick;
                if (i_tx_done_tick) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state      <= ST_IDLE;
            o_alu_a    <= '0;
            o_alu_b    <= '0;
            o_alu_op   <= '0;
            o_tx_data  <= '0;
            o_tx_start <= 1'b0;
            o_busy     <= 1'b0;
            o_timeout  <= 1'b0;
            o_op_err   <= 1'b0;
            o_overrun  <= 1'b0;
        end else begin
            state      <= state_nxt;
            o_alu_a    <= alu_a_nxt;
            o_alu_b    <= alu_b_nxt;
            o_alu_op   <= alu_op_nxt;
            o_tx_data  <= tx_data_nxt;
            o_tx_start <= tx_start_nxt;
            o_busy     <= (state_nxt != ST_IDLE);
            o_timeout  <= timeout_nxt;
            o_op_err   <= op_err_nxt;
            o_overrun  <= overrun_nxt;
        end
    end

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Directed bench for uart_alu_ctrl: vector table of byte triples plus timeout, overrun and reset sequences.
module tb_uart_alu_ctrl;

    logic       i_clock = 1'b0;
    logic       i_reset = 1'b0;
    logic       i_rx_done_tick = 1'b0;
    logic [7:0] i_rx_data = 8'h00;
    logic       i_tx_done_tick = 1'b0;
    logic [7:0] i_alu_result;
    logic [7:0] o_alu_a, o_alu_b, o_tx_data;
    logic [5:0] o_alu_op;
    logic       o_tx_start, o_busy, o_timeout, o_op_err, o_overrun;

    int checks   = 0;
    int failures = 0;
    int tx_starts = 0;
    logic [5:0] exp_op = 6'h00;

    always #5 i_clock = ~i_clock;

    uart_alu_ctrl #(
        .NB_DATA    (8),
        .NB_OP      (6),
        .NB_TIMEOUT (24),
        .N_TIMEOUT  (16)
    ) dut (
        .i_clock        (i_clock),
        .i_reset        (i_reset),
        .i_rx_done_tick (i_rx_done_tick),
        .i_rx_data      (i_rx_data),
        .i_tx_done_tick (i_tx_done_tick),
        .i_alu_result   (i_alu_result),
        .o_alu_a        (o_alu_a),
        .o_alu_b        (o_alu_b),
        .o_alu_op       (o_alu_op),
        .o_tx_start     (o_tx_start),
        .o_tx_data      (o_tx_data),
        .o_busy         (o_busy),
        .o_timeout      (o_timeout),
        .o_op_err       (o_op_err),
        .o_overrun      (o_overrun)
    );

    // Environment ALU, written independently of the design package.
    always_comb begin
        case (o_alu_op)
            6'b100000: i_alu_result = o_alu_a + o_alu_b;
            6'b100010: i_alu_result = o_alu_a - o_alu_b;
            6'b100100: i_alu_result = o_alu_a & o_alu_b;
            6'b100101: i_alu_result = o_alu_a | o_alu_b;
            6'b100110: i_alu_result = o_alu_a ^ o_alu_b;
            6'b100111: i_alu_result = ~(o_alu_a | o_alu_b);
            6'b000011: i_alu_result = 8'($signed(o_alu_a) >>> o_alu_b);
            6'b000010: i_alu_result = o_alu_a >> o_alu_b;
            default:   i_alu_result = 8'h00;
        endcase
    end

    always @(posedge i_clock) if (o_tx_start) tx_starts++;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] op;
        logic [7:0] res;
        logic       err;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge i_clock);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_rx_done_tick = 1'b1;
        i_rx_data      = b;
        @(posedge i_clock);
        #1;
        i_rx_done_tick = 1'b0;
    endtask

    task automatic pulse_tx_done();
        i_tx_done_tick = 1'b1;
        @(posedge i_clock);
        #1;
        i_tx_done_tick = 1'b0;
    endtask

    // Called right after the opcode byte has been captured (design in EXEC).
    task automatic finish_exec(input logic [7:0] res, input string tag);
        check({tag, "_exec_start"}, o_tx_start, 0);
        check({tag, "_exec_busy"}, o_busy, 1);
        step(1);
        check({tag, "_start"}, o_tx_start, 1);
        check({tag, "_txdata"}, o_tx_data, res);
        step(1);
        check({tag, "_start_end"}, o_tx_start, 0);
        check({tag, "_wait_busy"}, o_busy, 1);
        pulse_tx_done();
        check({tag, "_done_busy"}, o_busy, 0);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int starts_before;
        send_byte(v.a);
        step(1);
        send_byte(v.b);
        step(2);
        starts_before = tx_starts;
        send_byte(v.op);
        check({tag, "_a"}, o_alu_a, v.a);
        check({tag, "_b"}, o_alu_b, v.b);
        if (v.err) begin
            check({tag, "_op_err"}, o_op_err, 1);
            check({tag, "_op_kept"}, o_alu_op, exp_op);
            check({tag, "_err_busy"}, o_busy, 0);
            step(1);
            check({tag, "_op_err_end"}, o_op_err, 0);
            step(3);
            check({tag, "_no_start"}, tx_starts, starts_before);
        end else begin
            check({tag, "_op"}, o_alu_op, v.op[5:0]);
            check({tag, "_op_err"}, o_op_err, 0);
            finish_exec(v.res, tag);
            exp_op = v.op[5:0];
        end
    endtask

    initial begin
        int first_to;
        int to_cnt;
        int starts_before;

        vecs[0] = '{a: 8'h05, b: 8'h03, op: 8'h20, res: 8'h08, err: 1'b0};
        vecs[1] = '{a: 8'h03, b: 8'h05, op: 8'h22, res: 8'hFE, err: 1'b0};
        vecs[2] = '{a: 8'hF0, b: 8'h0F, op: 8'h27, res: 8'h00, err: 1'b0};
        vecs[3] = '{a: 8'h01, b: 8'h02, op: 8'h3F, res: 8'h00, err: 1'b1};
        vecs[4] = '{a: 8'h01, b: 8'h02, op: 8'h60, res: 8'h00, err: 1'b1};
        vecs[5] = '{a: 8'h0C, b: 8'h0A, op: 8'h25, res: 8'h0E, err: 1'b0};
        vecs[6] = '{a: 8'h81, b: 8'h02, op: 8'h03, res: 8'hE0, err: 1'b0};
        vecs[7] = '{a: 8'h81, b: 8'h02, op: 8'h26, res: 8'h83, err: 1'b0};

        #1;
        check("reset_a", o_alu_a, 0);
        check("reset_op", o_alu_op, 0);
        check("reset_txdata", o_tx_data, 0);
        check("reset_pulses", {o_tx_start, o_busy, o_timeout, o_op_err, o_overrun}, 0);
        step(2);
        i_reset = 1'b1;
        step(2);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // Stray tx_done in IDLE has no effect.
        starts_before = tx_starts;
        pulse_tx_done();
        check("stray_done_busy", o_busy, 0);
        check("stray_done_start", tx_starts, starts_before);

        // Timeout: A then silence.
        send_byte(8'hAA);
        check("to_enter_busy", o_busy, 1);
        first_to = -1;
        to_cnt   = 0;
        for (int k = 1; k <= 20; k++) begin
            step(1);
            if (o_timeout) begin
                to_cnt++;
                if (first_to < 0) first_to = k;
            end
            if (k == 15) check("to_idle", o_busy, 0);
        end
        check("to_cycle", first_to, 15);
        check("to_single_pulse", to_cnt, 1);
        run_vec('{a: 8'h0F, b: 8'h3C, op: 8'h24, res: 8'h0C, err: 1'b0}, "after_to");

        // Byte tick in the expiry cycle wins over the timeout.
        send_byte(8'h11);
        step(14);
        send_byte(8'h22);
        check("edge_no_timeout", o_timeout, 0);
        check("edge_b", o_alu_b, 8'h22);
        check("edge_busy", o_busy, 1);
        send_byte(8'h20);
        check("edge_op", o_alu_op, 6'h20);
        finish_exec(8'h33, "edge");

        // Overrun during WAIT_TX.
        send_byte(8'h0F);
        send_byte(8'h3C);
        send_byte(8'h24);
        step(2);
        check("ovr_pre", o_overrun, 0);
        send_byte(8'h77);
        check("ovr_pulse", o_overrun, 1);
        check("ovr_txdata", o_tx_data, 8'h0C);
        check("ovr_busy", o_busy, 1);
        check("ovr_a_kept", o_alu_a, 8'h0F);
        step(1);
        check("ovr_pulse_end", o_overrun, 0);
        check("ovr_still_busy", o_busy, 1);
        pulse_tx_done();
        check("ovr_done_busy", o_busy, 0);

        // Reset while in WAIT_TX.
        send_byte(8'h05);
        send_byte(8'h03);
        send_byte(8'h20);
        step(2);
        check("rst_pre_busy", o_busy, 1);
        i_reset = 1'b0;
        #2;
        check("rst_a", o_alu_a, 0);
        check("rst_b", o_alu_b, 0);
        check("rst_op", o_alu_op, 0);
        check("rst_txdata", o_tx_data, 0);
        check("rst_flags", {o_tx_start, o_busy, o_timeout, o_op_err, o_overrun}, 0);
        step(2);
        i_reset = 1'b1;
        exp_op  = 6'h00;
        step(1);
        run_vec('{a: 8'h09, b: 8'h04, op: 8'h22, res: 8'h05, err: 1'b0}, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_alu_ctrl.md
Name: uart_alu_ctrl

Overview:
- Sequencer between the UART receiver, the ALU and the UART transmitter.
- Collects three received bytes in order (operand A, operand B, opcode) and presents them to the combinational ALU.
- Captures the ALU result and launches one transmit of it; one operation per frame triple.
- Adds inter-byte timeout, opcode validation and overrun flagging.

Parameters:
NB_DATA, 8, data/operand/result width
NB_OP, 6, ALU opcode width
NB_TIMEOUT, 24, width of inter-byte timeout counter
N_TIMEOUT, 1000000, clock cycles allowed between consecutive bytes of one triple (>=2)

Ports:
i_clock  in  1  system clock
i_reset  in  1  asynchronous, active-low reset
i_rx_done_tick  in  1  one-cycle pulse, received byte valid on i_rx_data
i_rx_data  in  NB_DATA  received byte
i_tx_done_tick  in  1  one-cycle pulse, transmitter finished stop bit
i_alu_result  in  NB_DATA  combinational ALU result for o_alu_a/o_alu_b/o_alu_op
o_alu_a  out  NB_DATA  registered operand A
o_alu_b  out  NB_DATA  registered operand B
o_alu_op  out  NB_OP  registered opcode
o_tx_start  out  1  one-cycle pulse requesting transmission
o_tx_data  out  NB_DATA  registered byte to transmit, stable from o_tx_start until next capture
o_busy  out  1  high in any state except IDLE
o_timeout  out  1  one-cycle pulse, triple abandoned on timeout
o_op_err  out  1  one-cycle pulse, invalid opcode byte discarded
o_overrun  out  1  one-cycle pulse, byte received while executing/transmitting

Behaviour:
- Reset (i_reset=0, async): state IDLE, all outputs and internal registers 0.
- All outputs registered; pulse outputs high exactly one cycle.
- States: IDLE -> WAIT_B -> WAIT_OP -> EXEC -> SEND -> WAIT_TX -> IDLE.
- IDLE: on i_rx_done_tick, o_alu_a<=i_rx_data, clear timer, go WAIT_B.
- WAIT_B: on i_rx_done_tick, o_alu_b<=i_rx_data, clear timer, go WAIT_OP.
- WAIT_OP: on i_rx_done_tick:
  - Byte valid (upper NB_DATA-NB_OP bits zero and low NB_OP bits in the valid opcode set): o_alu_op<=byte[NB_OP-1:0], go EXEC.
  - Otherwise: o_op_err pulse, go IDLE; A/B/op registers keep their old values.
- Valid opcodes: ADD 6'b100000, SUB 6'b100010, AND 6'b100100, OR 6'b100101, XOR 6'b100110, NOR 6'b100111, SRA 6'b000011, SRL 6'b000010.
- Timer:
  - Counts every cycle in WAIT_B and WAIT_OP; zero elsewhere.
  - When it reaches N_TIMEOUT-1 without a byte: o_timeout pulse, go IDLE.
  - Byte tick in the same cycle as expiry: byte wins, no timeout.
- EXEC (one cycle): o_tx_data<=i_alu_result, go SEND.
- SEND: o_tx_start=1 for this cycle, go WAIT_TX.
- Latency: op byte tick at cycle N -> EXEC at N+1 -> o_tx_start high at N+2, with o_tx_data valid at N+2.
- WAIT_TX: on i_tx_done_tick go IDLE. A new A byte is accepted from the cycle after.
- i_rx_done_tick in EXEC, SEND or WAIT_TX: byte dropped, o_overrun pulse, no state change.
- i_tx_done_tick outside WAIT_TX: ignored.
- Reset mid-operation: immediate return to IDLE, no o_tx_start, partial triple lost.

Decomposition:
- Shared include/package uart_alu_defs: opcode localparams, state encodings (NB_STATE=3), default widths; reused by the ALU and the top level.
- One sub-module, inter_byte_timer: counter with clear/enable inputs and an expired output, parameterised by NB_TIMEOUT/N_TIMEOUT.

Test Plan:
- Bytes 0x05, 0x03, 0x20 (ADD), ALU model adds -> o_alu_a=0x05, o_alu_b=0x03, o_alu_op=0x20; o_tx_start 2 cycles after third tick with o_tx_data=0x08; o_busy high until i_tx_done_tick.
- Bytes 0x03, 0x05, 0x22 (SUB) -> o_tx_data=0xFE; next triple 0xF0, 0x0F, 0x27 (NOR) after tx done -> o_tx_data=0x00.
- Bytes 0x01, 0x02, 0x3F -> o_op_err single pulse, no o_tx_start, state IDLE; also 0x60 (upper bits set) -> o_op_err.
- N_TIMEOUT=16: byte 0xAA, then silence -> o_timeout exactly 15 cycles after entering WAIT_B; following 3 bytes form a fresh triple.
- Byte tick during WAIT_TX -> o_overrun pulse, o_tx_data unchanged, completion only on i_tx_done_tick.
- Assert i_reset=0 in WAIT_TX, release -> all outputs 0, o_busy 0, a new triple completes normally.
